// File: rtl/opt_sequencer.sv
// opt_sequencer: run controller that issues five datapath phases per iteration for a host-requested number of iterations.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   run_req/run_com/run_count  host start request with its command and iteration count
//   abort               finish the current iteration, then end the run
//   opt_run, opt_com    iteration-start pulse and command to the datapath (THR when not running)
//   phase_start/phase_done  one-hot phase kick and per-phase completion pulse
//   exch_odd            pairing parity for the exchange phases, toggles per iteration
//   host_req/host_gnt   host access to ordering/distance memories, granted only while idle
//   busy, done, timeout_err, iter_cnt  run status
module opt_sequencer #(
    parameter int CNT_W = 16,
    parameter int TO_W  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic [2:0]       run_com,
    input  logic [CNT_W-1:0] run_count,
    input  logic             abort,
    output logic             opt_run,
    output logic [2:0]       opt_com,
    output logic [4:0]       phase_start,
    input  logic [4:0]       phase_done,
    output logic             exch_odd,
    input  logic             host_req,
    output logic             host_gnt,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] iter_cnt
);
    localparam logic [2:0] THR = 3'd0;
    // Last WAIT cycle before the timeout counter would reach its all-ones value.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH, ERROR} state_t;
    state_t state, state_nx;
    logic [2:0] phase;
    logic [TO_W-1:0] to_cnt;
    logic [CNT_W-1:0] count_q;
    logic [2:0] com_q;
    logic abort_q, zero_done, accept, abort_seen, last_iter;
    assign accept     = state == IDLE && run_req && !host_req;
    assign abort_seen = abort_q || abort;
    assign last_iter  = (iter_cnt + CNT_W'(1)) == count_q;
    always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept && run_count != '0 ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = phase_done[phase] ? NEXT : to_cnt == TO_LAST ? ERROR : WAIT;
            NEXT:    state_nx = phase == 3'd4 && (last_iter || abort_seen) ? FINISH : ISSUE;
            FINISH:  state_nx = IDLE;
            default: state_nx = ERROR;
        endcase
    end
    always_comb begin
        busy        = state inside {ISSUE, WAIT, NEXT, ERROR};
        opt_run     = state == ISSUE && phase == 3'd0;
        phase_start = state == ISSUE ? 5'(1) << phase : 5'd0;
        opt_com     = state inside {ISSUE, WAIT, NEXT} ? com_q : THR;
        done        = state == FINISH || zero_done;
        host_gnt    = state == IDLE && host_req;
        timeout_err = state == ERROR;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= '0;
            to_cnt    <= '0;
            count_q   <= '0;
            com_q     <= THR;
            abort_q   <= 1'b0;
            zero_done <= 1'b0;
            iter_cnt  <= '0;
            exch_odd  <= 1'b0;
        end else begin
            zero_done <= accept && run_count == '0;
            if (accept) begin
                count_q  <= run_count;
                com_q    <= run_com;
                iter_cnt <= '0;
                abort_q  <= 1'b0;
                phase    <= '0;
            end
            if (busy && abort) abort_q <= 1'b1;
            if (state == ISSUE) to_cnt <= '0;
            if (state == WAIT) to_cnt <= to_cnt + TO_W'(1);
            if (state == NEXT) begin
                phase <= phase == 3'd4 ? 3'd0 : phase + 3'd1;
                if (phase == 3'd4) begin
                    exch_odd <= !exch_odd;
                    if (iter_cnt != count_q) iter_cnt <= iter_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_opt_sequencer.sv
// tb_opt_sequencer: directed bench for opt_sequencer with a per-cycle reference model and hand-computed checks.
module tb_opt_sequencer;
    localparam int CNT_W = 16;
    localparam int TO_W = 4;
    localparam logic [2:0] THR = 3'd0;
    logic clk = 1'b0;
    logic reset = 1'b1, run_req = 1'b0, abort = 1'b0, host_req = 1'b0;
    logic [2:0] run_com = 3'd0;
    logic [CNT_W-1:0] run_count = '0;
    logic [4:0] phase_done = 5'd0;
    logic opt_run, exch_odd, host_gnt, busy, done, timeout_err;
    logic [2:0] opt_com;
    logic [4:0] phase_start;
    logic [CNT_W-1:0] iter_cnt;
    int passed = 0, total = 0, cyc = 0;
    always #5 clk = ~clk;
    opt_sequencer #(.CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset), .run_req(run_req), .run_com(run_com),
        .run_count(run_count), .abort(abort), .opt_run(opt_run), .opt_com(opt_com),
        .phase_start(phase_start), .phase_done(phase_done), .exch_odd(exch_odd),
        .host_req(host_req), .host_gnt(host_gnt), .busy(busy), .done(done),
        .timeout_err(timeout_err), .iter_cnt(iter_cnt)
    );
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask
    // Datapath stand-in: answers each phase_start with phase_done dly cycles later.
    int dly = 3;
    logic [4:0] hold = 5'd0;
    logic early = 1'b0, noise = 1'b0;
    int cnt_d [5] = '{default: 0};
    int last_ph = 0;
    always @(negedge clk) begin
        logic [4:0] pd;
        pd = 5'd0;
        for (int b = 0; b < 5; b++) begin
            if (cnt_d[b] > 0) begin
                cnt_d[b]--;
                if (cnt_d[b] == 0) pd[b] = 1'b1;
            end
            if (phase_start[b] && !hold[b]) begin
                cnt_d[b] = dly;
                if (early) pd[b] = 1'b1;
            end
            if (phase_start[b]) last_ph = b;
        end
        if (noise) pd[(last_ph + 2) % 5] = 1'b1;
        phase_done = pd;
    end
    // Reference model: what the current cycle must look like, advanced from the inputs sampled at each edge.
    logic m_active = 0, m_err = 0, m_start = 0, m_wait = 0, m_gap = 0, m_fin = 0, m_zd = 0, m_ab = 0, m_odd = 0;
    int m_ph = 0, m_waited = 0;
    logic [2:0] m_cmd = 3'd0;
    logic [CNT_W-1:0] m_cnt = '0, m_iter = '0;
    task automatic model_step();
        logic fin_now;
        fin_now = m_fin;
        m_fin = 0;
        m_zd = 0;
        if (reset) begin
            m_active = 0; m_err = 0; m_start = 0; m_wait = 0; m_gap = 0; m_ab = 0; m_odd = 0; m_iter = '0;
        end else if (m_err) begin
            m_start = 0;
        end else if (!m_active) begin
            if (!fin_now && run_req && !host_req) begin
                m_iter = '0;
                if (run_count == '0) m_zd = 1;
                else begin
                    m_active = 1; m_cmd = run_com; m_cnt = run_count; m_ab = 0; m_ph = 0; m_start = 1;
                end
            end
        end else begin
            if (abort) m_ab = 1;
            if (m_start) begin
                m_start = 0; m_wait = 1; m_waited = 0;
            end else if (m_wait) begin
                m_waited++;
                if (phase_done[m_ph]) begin
                    m_wait = 0; m_gap = 1;
                end else if (m_waited == 2 ** TO_W - 1) begin
                    m_wait = 0; m_active = 0; m_err = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
                if (m_ph < 4) begin
                    m_ph++; m_start = 1;
                end else begin
                    m_iter = m_iter + 1'b1;
                    m_odd = !m_odd;
                    if (m_iter == m_cnt || m_ab) begin
                        m_active = 0; m_fin = 1;
                    end else begin
                        m_ph = 0; m_start = 1;
                    end
                end
            end
        end
    endtask
    logic [4:0] ps_log [$];
    int n_ps = 0, n_run = 0, n_done = 0, n_tog = 0, last_ps_cyc = 0;
    logic prev_odd = 1'b0;
    always @(posedge clk) begin
        #1;
        cyc++;
        model_step();
        check("phase_start", phase_start, m_start ? 5'(1) << m_ph : 5'd0);
        check("opt_run", opt_run, m_start && m_ph == 0);
        check("busy", busy, m_active || m_err);
        check("done", done, m_fin || m_zd);
        check("timeout_err", timeout_err, m_err);
        check("host_gnt", host_gnt, host_req && !m_active && !m_err && !m_fin);
        check("opt_com", opt_com, m_active ? m_cmd : THR);
        check("iter_cnt", iter_cnt, m_iter);
        check("exch_odd", exch_odd, m_odd);
        if (phase_start != 5'd0) begin
            n_ps++;
            ps_log.push_back(phase_start);
            last_ps_cyc = cyc;
        end
        if (opt_run) n_run++;
        if (done) n_done++;
        if (exch_odd !== prev_odd) n_tog++;
        prev_odd = exch_odd;
    end
    task automatic run_cmd(logic [2:0] cmd, int count);
        @(negedge clk);
        run_req = 1'b1;
        run_com = cmd;
        run_count = CNT_W'(count);
        @(negedge clk);
        run_req = 1'b0;
    endtask
    task automatic wait_done(string name, int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(name, i < budget, 1);
    endtask
    task automatic wait_starts(string name, int target, int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_ps >= target) break;
        end
        check(name, i < budget, 1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int b_ps, b_run, b_done, b_tog, b_log, i;
        logic ok;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_com", opt_com, THR);
        check("rst_iter", iter_cnt, 0);
        reset = 1'b0;
        // Test 1: two full iterations
        b_ps = n_ps; b_run = n_run; b_done = n_done; b_tog = n_tog; b_log = ps_log.size();
        run_cmd(3'd5, 2);
        check("t1_com", opt_com, 3'd5);
        wait_done("t1_done", 100);
        check("t1_busy_fin", busy, 0);
        check("t1_iter", iter_cnt, 2);
        check("t1_starts", n_ps - b_ps, 10);
        check("t1_runs", n_run - b_run, 2);
        check("t1_toggles", n_tog - b_tog, 2);
        check("t1_odd", exch_odd, 0);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) if (ps_log[b_log + k] !== 5'(1) << (k % 5)) ok = 1'b0;
        check("t1_order", ok, 1);
        repeat (3) @(negedge clk);
        check("t1_done_once", n_done - b_done, 1);
        check("t1_com_idle", opt_com, THR);
        // Test 2: zero-count run
        b_ps = n_ps; b_run = n_run;
        @(negedge clk);
        run_req = 1'b1; run_com = 3'd2; run_count = '0;
        @(negedge clk);
        run_req = 1'b0;
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        check("t2_iter", iter_cnt, 0);
        @(negedge clk);
        check("t2_done_pulse", done, 0);
        repeat (3) @(negedge clk);
        check("t2_starts", n_ps - b_ps, 0);
        check("t2_runs", n_run - b_run, 0);
        // Test 3: abort during phase 2 of the second iteration, with spurious done bits
        noise = 1'b1;
        b_ps = n_ps; b_done = n_done;
        run_cmd(3'd3, 5);
        wait_starts("t3_reach", b_ps + 8, 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("t3_done", 100);
        check("t3_iter", iter_cnt, 2);
        check("t3_starts", n_ps - b_ps, 10);
        check("t3_done_once", n_done - b_done, 1);
        noise = 1'b0;
        // Test 4: phase 1 never completes
        hold = 5'b00010;
        b_ps = n_ps; b_done = n_done;
        run_cmd(3'd6, 3);
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (timeout_err) break;
        end
        check("t4_error", i < 60, 1);
        check("t4_gap", cyc - last_ps_cyc, 16);
        check("t4_busy", busy, 1);
        check("t4_com", opt_com, THR);
        repeat (5) @(negedge clk);
        check("t4_sticky", timeout_err, 1);
        check("t4_starts", n_ps - b_ps, 2);
        check("t4_no_done", n_done - b_done, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hold = 5'd0;
        check("t4_rst_busy", busy, 0);
        check("t4_rst_err", timeout_err, 0);
        check("t4_rst_iter", iter_cnt, 0);
        check("t4_rst_odd", exch_odd, 0);
        check("t4_rst_com", opt_com, THR);
        check("t4_rst_ps", phase_start, 0);
        check("t4_rst_done", done, 0);
        check("t4_rst_run", opt_run, 0);
        // Test 5: host arbitration; done echoed in the issue cycle must be ignored
        b_done = n_done;
        @(negedge clk);
        host_req = 1'b1; run_req = 1'b1; run_com = 3'd4; run_count = CNT_W'(3);
        @(negedge clk);
        run_req = 1'b0;
        check("t5_gnt", host_gnt, 1);
        check("t5_ignored", busy, 0);
        repeat (2) @(negedge clk);
        check("t5_still_idle", busy, 0);
        check("t5_no_done", n_done - b_done, 0);
        host_req = 1'b0;
        early = 1'b1;
        run_cmd(3'd4, 1);
        repeat (3) @(negedge clk);
        host_req = 1'b1;
        @(negedge clk);
        check("t5_gnt_busy", host_gnt, 0);
        wait_done("t5_done", 100);
        check("t5_gnt_fin", host_gnt, 0);
        check("t5_iter", iter_cnt, 1);
        @(negedge clk);
        check("t5_gnt_idle", host_gnt, 1);
        host_req = 1'b0;
        early = 1'b0;
        // Test 6: reset in the WAIT of iteration 3
        b_ps = n_ps; b_done = n_done;
        run_cmd(3'd7, 5);
        wait_starts("t6_reach", b_ps + 16, 200);
        @(negedge clk);
        check("t6_iter_mid", iter_cnt, 3);
        check("t6_com_mid", opt_com, 3'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_iter", iter_cnt, 0);
        check("t6_com", opt_com, THR);
        repeat (10) @(negedge clk);
        check("t6_no_done", n_done - b_done, 0);
        check("t6_no_start", n_ps - b_ps, 16);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
